// File: rtl/fp_pkg.sv
// Shared definitions for the FP compare/min/max datapath: op encodings,
// ordering codes, per-operand class bundle and the canonical quiet NaN.
package fp_pkg;

    localparam logic [2:0] FOP_FEQ  = 3'b000;
    localparam logic [2:0] FOP_FLT  = 3'b001;
    localparam logic [2:0] FOP_FLE  = 3'b010;
    localparam logic [2:0] FOP_FMIN = 3'b011;
    localparam logic [2:0] FOP_FMAX = 3'b100;

    localparam logic [1:0] CMP_EQ = 2'b00;
    localparam logic [1:0] CMP_GT = 2'b01;
    localparam logic [1:0] CMP_LT = 2'b10;
    localparam logic [1:0] CMP_UN = 2'b11;

    typedef struct packed {
        logic is_nan;
        logic is_snan;
        logic is_zero;
    } fp_class_t;

    // Canonical NaN: sign 0, exponent all ones, mantissa MSB set, rest 0.
    // Returned zero-extended to 64 bits; callers truncate to their width.
    function automatic logic [63:0] fp_canon_nan(input int exp_w, input int man_w);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < 64; i++) begin
            if ((i >= man_w) && (i < man_w + exp_w)) v[i] = 1'b1;
            if (i == man_w - 1) v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational operand classifier: NaN, signalling NaN and zero detection.
// Takes only the exponent/mantissa field; the sign never affects the class.
module fp_classify #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W+MAN_W-1:0] i_mag,
    output logic                   o_is_nan,
    output logic                   o_is_snan,
    output logic                   o_is_zero
);

    logic [EXP_W-1:0] w_exp;
    logic [MAN_W-1:0] w_man;

    assign w_exp = i_mag[EXP_W+MAN_W-1:MAN_W];
    assign w_man = i_mag[MAN_W-1:0];

    // Decode the class bits from the exponent/mantissa fields.
    always_comb begin
        o_is_nan  = (&w_exp) && (|w_man);
        o_is_snan = o_is_nan && !w_man[MAN_W-1];
        o_is_zero = !(|w_exp) && !(|w_man);
    end

endmodule

// File: rtl/fp_compare_pipe.sv
// Two-stage pipelined IEEE-754 compare/min/max unit (FEQ/FLT/FLE/FMIN/FMAX).
// Stage 1 captures operands, op, tag and operand classes; stage 2 captures
// the final result, ordering code and invalid flag.
//
// Handshake: an item transfers on a port in any cycle where valid and ready
// are both high at the rising clock edge. Valid, once raised, holds with its
// payload stable until ready is seen. in_ready is combinational from
// out_ready so a full pipe can still accept when the consumer drains.
module fp_compare_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 5,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a_operand,
    input  logic [W-1:0]     b_operand,
    input  logic [2:0]       op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     result,
    output logic [1:0]       cmp_code,
    output logic             flag_nv,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [63:0]  CANON_NAN_64 = fp_canon_nan(EXP_W, MAN_W);
    localparam logic [W-1:0] CANON_NAN    = CANON_NAN_64[W-1:0];

    // Stage 1 registers
    logic             r_s1_valid;
    logic [W-1:0]     r_s1_a;
    logic [W-1:0]     r_s1_b;
    logic [2:0]       r_s1_op;
    logic [TAG_W-1:0] r_s1_tag;
    fp_class_t        r_s1_a_cls;
    fp_class_t        r_s1_b_cls;

    // Stage 2 (output) registers
    logic             r_s2_valid;
    logic [W-1:0]     r_result;
    logic [1:0]       r_cmp_code;
    logic             r_flag_nv;
    logic [TAG_W-1:0] r_out_tag;

    // Flow control
    logic w_s2_adv;
    logic w_s1_adv;

    // Classifier outputs on the incoming operands
    fp_class_t w_a_cls;
    fp_class_t w_b_cls;

    // Stage 2 combinational results
    logic         w_a_sign;
    logic         w_b_sign;
    logic [W-2:0] w_a_mag;
    logic [W-2:0] w_b_mag;
    logic         w_any_nan;
    logic         w_any_snan;
    logic [1:0]   w_cmp;
    logic [W-1:0] w_min;
    logic [W-1:0] w_max;
    logic [W-1:0] w_result;
    logic         w_nv;

    assign w_s2_adv  = !r_s2_valid || out_ready;
    assign w_s1_adv  = !r_s1_valid || w_s2_adv;
    assign in_ready  = w_s1_adv;

    assign out_valid = r_s2_valid;
    assign result    = r_result;
    assign cmp_code  = r_cmp_code;
    assign flag_nv   = r_flag_nv;
    assign out_tag   = r_out_tag;

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_class_a (
        .i_mag     (a_operand[W-2:0]),
        .o_is_nan  (w_a_cls.is_nan),
        .o_is_snan (w_a_cls.is_snan),
        .o_is_zero (w_a_cls.is_zero)
    );

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_class_b (
        .i_mag     (b_operand[W-2:0]),
        .o_is_nan  (w_b_cls.is_nan),
        .o_is_snan (w_b_cls.is_snan),
        .o_is_zero (w_b_cls.is_zero)
    );

    // Stage 1: capture an accepted item with its operand classes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_op    <= '0;
            r_s1_tag   <= '0;
            r_s1_a_cls <= '0;
            r_s1_b_cls <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_a     <= a_operand;
                r_s1_b     <= b_operand;
                r_s1_op    <= op;
                r_s1_tag   <= in_tag;
                r_s1_a_cls <= w_a_cls;
                r_s1_b_cls <= w_b_cls;
            end
        end
    end

    // Ordering of the stage-1 operands (NaN, signed zero, sign-magnitude).
    always_comb begin
        w_a_sign   = r_s1_a[W-1];
        w_b_sign   = r_s1_b[W-1];
        w_a_mag    = r_s1_a[W-2:0];
        w_b_mag    = r_s1_b[W-2:0];
        w_any_nan  = r_s1_a_cls.is_nan || r_s1_b_cls.is_nan;
        w_any_snan = r_s1_a_cls.is_snan || r_s1_b_cls.is_snan;
        w_cmp      = CMP_EQ;
        if (w_any_nan) begin
            w_cmp = CMP_UN;
        end else if (r_s1_a_cls.is_zero && r_s1_b_cls.is_zero) begin
            w_cmp = CMP_EQ;
        end else if (w_a_sign != w_b_sign) begin
            w_cmp = w_a_sign ? CMP_LT : CMP_GT;
        end else if (w_a_mag == w_b_mag) begin
            w_cmp = CMP_EQ;
        end else if (!w_a_sign) begin
            w_cmp = (w_a_mag > w_b_mag) ? CMP_GT : CMP_LT;
        end else begin
            w_cmp = (w_a_mag < w_b_mag) ? CMP_GT : CMP_LT;
        end
    end

    // Min/max selection, including NaN propagation and the -0 < +0 rule.
    always_comb begin
        w_min = r_s1_a;
        w_max = r_s1_a;
        if (r_s1_a_cls.is_nan && r_s1_b_cls.is_nan) begin
            w_min = CANON_NAN;
            w_max = CANON_NAN;
        end else if (r_s1_a_cls.is_nan) begin
            w_min = r_s1_b;
            w_max = r_s1_b;
        end else if (r_s1_b_cls.is_nan) begin
            w_min = r_s1_a;
            w_max = r_s1_a;
        end else if (r_s1_a_cls.is_zero && r_s1_b_cls.is_zero) begin
            w_min = w_a_sign ? r_s1_a : r_s1_b;
            w_max = w_a_sign ? r_s1_b : r_s1_a;
        end else if (w_cmp == CMP_LT) begin
            w_min = r_s1_a;
            w_max = r_s1_b;
        end else if (w_cmp == CMP_GT) begin
            w_min = r_s1_b;
            w_max = r_s1_a;
        end
    end

    // Per-op result and invalid flag; reserved ops give zero result and flag.
    always_comb begin
        w_result = '0;
        w_nv     = 1'b0;
        case (r_s1_op)
            FOP_FEQ: begin
                w_result[0] = (w_cmp == CMP_EQ);
                w_nv        = w_any_snan;
            end
            FOP_FLT: begin
                w_result[0] = (w_cmp == CMP_LT);
                w_nv        = w_any_nan;
            end
            FOP_FLE: begin
                w_result[0] = (w_cmp == CMP_LT) || (w_cmp == CMP_EQ);
                w_nv        = w_any_nan;
            end
            FOP_FMIN: begin
                w_result = w_min;
                w_nv     = w_any_snan;
            end
            FOP_FMAX: begin
                w_result = w_max;
                w_nv     = w_any_snan;
            end
            default: begin
                w_result = '0;
                w_nv     = 1'b0;
            end
        endcase
    end

    // Stage 2: register outputs; they hold while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_result   <= '0;
            r_cmp_code <= '0;
            r_flag_nv  <= 1'b0;
            r_out_tag  <= '0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_result   <= w_result;
                r_cmp_code <= w_cmp;
                r_flag_nv  <= w_nv;
                r_out_tag  <= r_s1_tag;
            end
        end
    end

endmodule

// File: tb/tb_fp_compare_pipe.sv
// Directed-vector bench for fp_compare_pipe with a scoreboard queue and an
// independent output monitor.
module tb_fp_compare_pipe;

  localparam int W     = 32;
  localparam int TAG_W = 5;
  localparam int EW    = W + 2 + 1 + TAG_W;

  localparam logic [2:0] OP_FEQ  = 3'b000;
  localparam logic [2:0] OP_FLT  = 3'b001;
  localparam logic [2:0] OP_FLE  = 3'b010;
  localparam logic [2:0] OP_FMIN = 3'b011;
  localparam logic [2:0] OP_FMAX = 3'b100;
  localparam logic [2:0] OP_RSV  = 3'b101;

  // ---------------- clock / reset ----------------
  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a_operand;
  logic [W-1:0]     b_operand;
  logic [2:0]       op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     result;
  logic [1:0]       cmp_code;
  logic             flag_nv;
  logic [TAG_W-1:0] out_tag;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fp_compare_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_operand (a_operand),
    .b_operand (b_operand),
    .op        (op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cmp_code  (cmp_code),
    .flag_nv   (flag_nv),
    .out_tag   (out_tag)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  logic          held = 1'b0;
  logic [EW-1:0] held_val;
  logic          stall_seen = 1'b0;

  task automatic check1(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at posedge+#1; returns at posedge+#1 of the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] o,
                      input logic [TAG_W-1:0] tag, input logic [W-1:0] er,
                      input logic [1:0] ec, input logic en);
    logic acc;
    int   n;
    in_valid  = 1'b1;
    a_operand = a;
    b_operand = b;
    op        = o;
    in_tag    = tag;
    acc       = 1'b0;
    n         = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) exp_q.push_back({er, ec, en, tag});
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: tag %0d not accepted in %0d cycles", tag, n);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // Item accepted at the previous edge must appear exactly 2 cycles later.
  task automatic check_latency(input string name);
    @(negedge clk);
    check1({name, "_lat1"}, {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    check1({name, "_lat2"}, {31'b0, out_valid}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [EW-1:0] got;
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (in_valid && !in_ready) stall_seen = 1'b1;
      if (rst_n && out_valid) begin
        got = {result, cmp_code, flag_nv, out_tag};
        if (held) begin
          checks++;
          if (got !== held_val) begin
            errors++;
            $display("FAIL hold_stable: got %h expected %h", got, held_val);
          end
        end
        if (out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out: got res %h cmp %b nv %b tag %0d with empty queue",
                     result, cmp_code, flag_nv, out_tag);
          end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
              errors++;
              $display("FAIL item_tag%0d: got res %h cmp %b nv %b tag %0d expected res %h cmp %b nv %b tag %0d",
                       e[TAG_W-1:0], result, cmp_code, flag_nv, out_tag,
                       e[EW-1:EW-W], e[EW-W-1:EW-W-2], e[TAG_W], e[TAG_W-1:0]);
            end
          end
          held = 1'b0;
        end else begin
          held     = 1'b1;
          held_val = got;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a_operand = '0;
    b_operand = '0;
    op        = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check1("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check1("reset_result", result, 32'd0);
    check1("reset_side", {25'b0, cmp_code, flag_nv, out_tag}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1.0 < 2.0, with explicit latency check
    send(32'h3F800000, 32'h40000000, OP_FLT, 5'd1, 32'd1, 2'b10, 1'b0);
    idle();
    check_latency("flt");

    // signed zeros
    send(32'h80000000, 32'h00000000, OP_FEQ,  5'd2, 32'd1,        2'b00, 1'b0);
    send(32'h80000000, 32'h00000000, OP_FMIN, 5'd3, 32'h80000000, 2'b00, 1'b0);
    send(32'h80000000, 32'h00000000, OP_FMAX, 5'd4, 32'h00000000, 2'b00, 1'b0);
    send(32'h00000000, 32'h80000000, OP_FMIN, 5'd5, 32'h80000000, 2'b00, 1'b0);
    // NaN handling
    send(32'h7F800001, 32'h3F800000, OP_FEQ,  5'd6, 32'd0,        2'b11, 1'b1);
    send(32'h7F800001, 32'h3F800000, OP_FMAX, 5'd7, 32'h3F800000, 2'b11, 1'b1);
    send(32'h7F800001, 32'h3F800000, OP_FLT,  5'd8, 32'd0,        2'b11, 1'b1);
    send(32'h7FC00001, 32'h7FC00001, OP_FMIN, 5'd9, 32'h7FC00000, 2'b11, 1'b0);
    send(32'h7FC00000, 32'h3F800000, OP_FEQ,  5'd10, 32'd0,       2'b11, 1'b0);
    send(32'h3F800000, 32'h7FC00000, OP_FLE,  5'd11, 32'd0,       2'b11, 1'b1);
    send(32'h7FC00000, 32'hBF800000, OP_FMIN, 5'd12, 32'hBF800000, 2'b11, 1'b0);
    // negative ordering
    send(32'hC0000000, 32'hBF800000, OP_FLE,  5'd13, 32'd1, 2'b10, 1'b0);
    send(32'hBF800000, 32'hC0000000, OP_FLE,  5'd14, 32'd0, 2'b01, 1'b0);
    // mixed / magnitudes
    send(32'h3F800000, 32'h40000000, OP_FMIN, 5'd15, 32'h3F800000, 2'b10, 1'b0);
    send(32'hC0000000, 32'h3F800000, OP_FMAX, 5'd16, 32'h3F800000, 2'b10, 1'b0);
    send(32'h3F800000, 32'h3F800000, OP_FLE,  5'd17, 32'd1, 2'b00, 1'b0);
    send(32'h7F800000, 32'h7F7FFFFF, OP_FLT,  5'd18, 32'd0, 2'b01, 1'b0);
    send(32'hC0000000, 32'hBF800000, OP_FMAX, 5'd19, 32'hBF800000, 2'b10, 1'b0);
    // reserved op
    send(32'h3F800000, 32'h40000000, OP_RSV,  5'd20, 32'd0, 2'b10, 1'b0);
    idle();
    repeat (4) @(posedge clk);
    #1;

    // backpressure: 6 back-to-back, out_ready low for 4 cycles
    stall_seen = 1'b0;
    fork
      begin
        send(32'h3F800000, 32'h40000000, OP_FMAX, 5'd21, 32'h40000000, 2'b10, 1'b0);
        send(32'h40000000, 32'h3F800000, OP_FMAX, 5'd22, 32'h40000000, 2'b01, 1'b0);
        send(32'hBF800000, 32'h3F800000, OP_FMIN, 5'd23, 32'hBF800000, 2'b10, 1'b0);
        send(32'h3F800000, 32'h3F800000, OP_FEQ,  5'd24, 32'd1,        2'b00, 1'b0);
        send(32'h00000000, 32'h3F800000, OP_FLT,  5'd25, 32'd1,        2'b10, 1'b0);
        send(32'h40000000, 32'hC0000000, OP_FLE,  5'd26, 32'd0,        2'b01, 1'b0);
        idle();
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    check1("bp_stall_seen", {31'b0, stall_seen}, 32'd1);
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check1("bp_drained", exp_q.size(), 32'd0);

    // reset with 2 items in flight
    out_ready = 1'b0;
    send(32'h3F800000, 32'h40000000, OP_FLT, 5'd27, 32'd1, 2'b10, 1'b0);
    send(32'h3F800000, 32'h40000000, OP_FEQ, 5'd28, 32'd0, 2'b10, 1'b0);
    idle();
    rst_n = 1'b0;
    #1;
    check1("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
    check1("rst_mid_result", result, 32'd0);
    exp_q.delete();
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(32'hC0000000, 32'hBF800000, OP_FMIN, 5'd29, 32'hC0000000, 2'b10, 1'b0);
    idle();
    check_latency("post_rst");

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check1("final_drained", exp_q.size(), 32'd0);
    repeat (5) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_compare_pipe.md
Name: fp_compare_pipe

Overview:
- Pipelined, parametrised IEEE-754 compare/min/max unit for the FPU datapath of the RV32IM pipeline.
- Generalises the earlier combinational 2-bit magnitude compare. Adds:
  - configurable exponent/mantissa widths;
  - RISC-V FEQ/FLT/FLE/FMIN/FMAX operations;
  - NaN and signed-zero handling with an invalid flag;
  - valid/ready handshaking with backpressure.
- Sits between operand read and FP writeback; a tag rides alongside for instruction tracking.

Parameters:
- EXP_W, 8, exponent field width
- MAN_W, 23, mantissa field width; total width W = 1+EXP_W+MAN_W
- TAG_W, 5, width of pass-through tag (destination register)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands/op valid
- in_ready  out  1  unit can accept this cycle
- a_operand  in  W  operand A
- b_operand  in  W  operand B
- op  in  3  000 FEQ, 001 FLT, 010 FLE, 011 FMIN, 100 FMAX, others reserved
- in_tag  in  TAG_W  passed through unchanged
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- result  out  W  FEQ/FLT/FLE: {W-1 zeros, bit}; FMIN/FMAX: selected or canonical value
- cmp_code  out  2  00 equal, 01 a>b, 10 a<b, 11 unordered
- flag_nv  out  1  invalid-operation flag
- out_tag  out  TAG_W  tag of this result

Behaviour:
- Reset (async on rst_n low):
  - s1_valid, s2_valid, out_valid = 0; result, cmp_code, flag_nv, out_tag = 0.
  - Reset mid-operation drops all in-flight items with no output.
- Pipeline: two register stages.
  - S1 registers operands, op and tag, plus classification: isNaN, isSNaN, isZero per operand.
  - S2 registers the computed outputs.
  - Latency is exactly 2 cycles from accept (in_valid & in_ready) to out_valid when out_ready is held high.
  - Throughput is 1 item per cycle.
- Handshake:
  - S2 advances when !s2_valid | out_ready.
  - S1 advances when !s1_valid | S2 advances.
  - in_ready = S1 advances; it is combinational from out_ready (no skid buffer required).
  - While out_valid & !out_ready, result, cmp_code, flag_nv and out_tag stay stable.
  - No item is lost or duplicated under any valid/ready pattern.
- Classification:
  - NaN = exponent all ones and mantissa != 0.
  - sNaN = NaN with mantissa MSB 0.
  - Zero = exponent and mantissa both 0.
- Ordering:
  - If either operand is NaN, cmp_code = 11.
  - Else if both are zero (any signs), cmp_code = 00 (+0 == -0).
  - Else compare sign-magnitude:
    - differing signs: the positive operand is greater;
    - both positive: larger {exp,man} is greater;
    - both negative: smaller {exp,man} is greater.
- FEQ: result bit = (cmp_code == 00). flag_nv = either operand is sNaN.
- FLT: bit = (cmp_code == 10). FLE: bit = (cmp_code == 00 or 10). For both, flag_nv = either operand is NaN; bit = 0 when unordered.
- FMIN/FMAX:
  - Both NaN: canonical NaN = sign 0, exponent all ones, mantissa MSB 1, rest 0 (0x7FC00000 at default).
  - One NaN: return the other operand.
  - Otherwise return the smaller/larger operand.
  - For ±0 pairs, FMIN returns -0 and FMAX returns +0.
  - flag_nv = either operand is sNaN.
- Reserved op: result = 0, flag_nv = 0; cmp_code is still computed; the item is still handshaked.

Decomposition:
- Shared package fp_pkg holds:
  - op encodings (FOP_FEQ … FOP_FMAX);
  - cmp_code constants (CMP_EQ, CMP_GT, CMP_LT, CMP_UN);
  - canonical-NaN constant function of EXP_W/MAN_W.
- One sub-module: fp_classify (combinational; outputs isNaN/isSNaN/isZero), instantiated twice in S1.

Test Plan:
- a=0x3F800000 (1.0), b=0x40000000 (2.0), op FLT, out_ready=1 -> after 2 cycles: out_valid=1, result=1, cmp_code=10, flag_nv=0.
- a=0x80000000 (-0), b=0x00000000 (+0): op FEQ -> result 1, cmp 00. op FMIN -> 0x80000000. op FMAX -> 0x00000000.
- a=0x7F800001 (sNaN), b=0x3F800000 (1.0):
  - FEQ -> 0, nv=1, cmp 11.
  - FMAX -> 0x3F800000, nv=1.
  - a=b=0x7FC00001, op FMIN -> 0x7FC00000, nv=0.
- a=0xC0000000 (-2.0), b=0xBF800000 (-1.0), FLE -> result 1, cmp 10. Swapped operands -> result 0, cmp 01.
- Backpressure: 6 back-to-back ops with out_ready low for cycles 3–6.
  - in_ready drops after 2 items are buffered.
  - Held outputs stay stable.
  - All 6 tags emerge in order, with none dropped or duplicated.
- Assert rst_n low with 2 items in flight -> out_valid=0 immediately. After release, a new op completes in 2 cycles with no stale output.
